// File: rtl/execute_md_pkg.sv
// Shared types and opcode constants for the EX stage and its multiply/divide unit.
package exec_pkg;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd8;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;
  localparam logic [1:0] BR_JMP  = 2'd3;

endpackage

// File: rtl/execute_md_md_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one result bit per step.
module md_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  md_op_t            op,
  output logic              done,
  output logic [DATA_W-1:0] res
);

  localparam int CNT_W = $clog2(DATA_W);

  // acc holds the product high half or the partial remainder; lo holds the
  // multiplier being consumed or the dividend turning into the quotient.
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  md_op_t            op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_div;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   rem_shift;
  logic              rem_ge;

  always_comb begin
    is_div    = (op_q == MD_DIVU) || (op_q == MD_REMU);
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = {acc_q, lo_q[DATA_W-1]};
    rem_ge    = (rem_shift >= {1'b0, opnd_q});
    done      = step && (cnt_q == CNT_W'(DATA_W - 1));

    opnd_d = opnd_q;
    acc_d  = acc_q;
    lo_d   = lo_q;
    op_d   = op_q;
    cnt_d  = cnt_q;

    if (start) begin
      opnd_d = b;
      lo_d   = a;
      acc_d  = '0;
      op_d   = op;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div) begin
        acc_d = rem_ge ? (rem_shift[DATA_W-1:0] - opnd_q) : rem_shift[DATA_W-1:0];
        lo_d  = {lo_q[DATA_W-2:0], rem_ge};
      end else begin
        {acc_d, lo_d} = {mul_sum, lo_q[DATA_W-1:1]};
      end
    end

    case (op_q)
      MD_MUL, MD_DIVU:  res = lo_q;
      default:          res = acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opnd_q <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      op_q   <= MD_MUL;
      cnt_q  <= '0;
    end else begin
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      lo_q   <= lo_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/execute_md.sv
// EX stage: single-cycle alu/branch path plus multi-cycle mul/div, owning the EX/MEM flops.
module execute_md
  import exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_BITS  = 16,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [DATA_W-1:0]   read1data,
  input  logic [DATA_W-1:0]   read2data,
  input  logic [DATA_W-1:0]   imm,
  input  logic                imm_sel,
  input  logic [3:0]          alu_op,
  input  logic                md_en,
  input  logic [1:0]          md_op,
  input  logic [1:0]          branch,
  input  logic [PC_BITS-1:0]  pc_d,
  input  logic [REG_BITS-1:0] writeregsel_d,
  input  logic                wb_sel_d,
  input  logic                write_d,
  input  logic                m_write_d,
  output logic                stall,
  output logic [DATA_W-1:0]   result,
  output logic [PC_BITS-1:0]  pc,
  output logic [REG_BITS-1:0] writeregsel,
  output logic                wb_sel,
  output logic                write,
  output logic                m_write
);

  localparam int SH_W = $clog2(DATA_W);

  md_state_t           state_q, state_d;
  logic [DATA_W-1:0]   ex_result_q, ex_result_d;
  logic [PC_BITS-1:0]  ex_pc_q, ex_pc_d;
  logic [REG_BITS-1:0] ex_wrsel_q, ex_wrsel_d;
  logic                ex_wb_sel_q, ex_wb_sel_d;
  logic                ex_write_q, ex_write_d;
  logic                ex_m_write_q, ex_m_write_d;

  logic [DATA_W-1:0]   opb, alu_res, md_res;
  logic [PC_BITS-1:0]  pc_seq, pc_next;
  logic                taken, md_start, md_step, md_done;

  function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] op,
                                              input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
    logic signed [DATA_W-1:0] sx, sy;
    sx = x;
    sy = y;
    case (op)
      ALU_ADD:   return x + y;
      ALU_SUB:   return x - y;
      ALU_AND:   return x & y;
      ALU_OR:    return x | y;
      ALU_XOR:   return x ^ y;
      ALU_SLL:   return x << y[SH_W-1:0];
      ALU_SRL:   return x >> y[SH_W-1:0];
      ALU_SLT:   return {{(DATA_W-1){1'b0}}, (sx < sy)};
      ALU_PASSB: return y;
      default:   return '0;
    endcase
  endfunction

  md_unit #(.DATA_W(DATA_W)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .step  (md_step),
    .a     (read1data),
    .b     (opb),
    .op    (md_op_t'(md_op)),
    .done  (md_done),
    .res   (md_res)
  );

  always_comb begin
    opb     = imm_sel ? imm : read2data;
    alu_res = alu_f(alu_op, read1data, opb);
    taken   = ((branch == BR_EQ) && (read1data == opb)) ||
              ((branch == BR_NE) && (read1data != opb)) ||
              (branch == BR_JMP);
    pc_seq  = pc_d + PC_BITS'(1);
    pc_next = taken ? (pc_d + imm[PC_BITS-1:0]) : pc_seq;

    stall    = ((state_q == IDLE) && md_en && !flush) || (state_q == BUSY);
    md_start = (state_q == IDLE) && md_en && !flush;
    md_step  = (state_q == BUSY) && !flush;

    // Default is a bubble: data fields hold, write enables drop.
    state_d      = state_q;
    ex_result_d  = ex_result_q;
    ex_pc_d      = ex_pc_q;
    ex_wrsel_d   = ex_wrsel_q;
    ex_wb_sel_d  = ex_wb_sel_q;
    ex_write_d   = 1'b0;
    ex_m_write_d = 1'b0;

    if (flush) begin
      state_d = IDLE;
      ex_pc_d = pc_d;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_en) begin
            state_d = BUSY;
          end else begin
            ex_result_d  = alu_res;
            ex_pc_d      = pc_next;
            ex_wrsel_d   = writeregsel_d;
            ex_wb_sel_d  = wb_sel_d;
            ex_write_d   = write_d;
            ex_m_write_d = m_write_d;
          end
        end
        BUSY: begin
          if (md_done) state_d = DONE;
        end
        default: begin
          // ID/EX has been held, so the live control fields still belong to the md instruction.
          state_d      = IDLE;
          ex_result_d  = md_res;
          ex_pc_d      = pc_seq;
          ex_wrsel_d   = writeregsel_d;
          ex_wb_sel_d  = wb_sel_d;
          ex_write_d   = write_d;
          ex_m_write_d = m_write_d;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ex_result_q  <= '0;
      ex_pc_q      <= '0;
      ex_wrsel_q   <= '0;
      ex_wb_sel_q  <= 1'b0;
      ex_write_q   <= 1'b0;
      ex_m_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ex_result_q  <= ex_result_d;
      ex_pc_q      <= ex_pc_d;
      ex_wrsel_q   <= ex_wrsel_d;
      ex_wb_sel_q  <= ex_wb_sel_d;
      ex_write_q   <= ex_write_d;
      ex_m_write_q <= ex_m_write_d;
    end
  end

  assign result      = ex_result_q;
  assign pc          = ex_pc_q;
  assign writeregsel = ex_wrsel_q;
  assign wb_sel      = ex_wb_sel_q;
  assign write       = ex_write_q;
  assign m_write     = ex_m_write_q;

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: alu path, mul/div latency and results, flush and reset.
module tb_execute_md;

  localparam int DATA_W   = 32;
  localparam int PC_BITS  = 16;
  localparam int REG_BITS = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic [DATA_W-1:0]   read1data, read2data, imm;
  logic                imm_sel;
  logic [3:0]          alu_op;
  logic                md_en;
  logic [1:0]          md_op;
  logic [1:0]          branch;
  logic [PC_BITS-1:0]  pc_d;
  logic [REG_BITS-1:0] writeregsel_d;
  logic                wb_sel_d, write_d, m_write_d;
  logic                stall;
  logic [DATA_W-1:0]   result;
  logic [PC_BITS-1:0]  pc;
  logic [REG_BITS-1:0] writeregsel;
  logic                wb_sel, write, m_write;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  execute_md #(.DATA_W(DATA_W), .PC_BITS(PC_BITS), .REG_BITS(REG_BITS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .read1data     (read1data),
    .read2data     (read2data),
    .imm           (imm),
    .imm_sel       (imm_sel),
    .alu_op        (alu_op),
    .md_en         (md_en),
    .md_op         (md_op),
    .branch        (branch),
    .pc_d          (pc_d),
    .writeregsel_d (writeregsel_d),
    .wb_sel_d      (wb_sel_d),
    .write_d       (write_d),
    .m_write_d     (m_write_d),
    .stall         (stall),
    .result        (result),
    .pc            (pc),
    .writeregsel   (writeregsel),
    .wb_sel        (wb_sel),
    .write         (write),
    .m_write       (m_write)
  );

  task automatic idle_inputs();
    flush = 0; read1data = 0; read2data = 0; imm = 0; imm_sel = 0;
    alu_op = 4'd0; md_en = 0; md_op = 2'd0; branch = 2'd0; pc_d = 0;
    writeregsel_d = 0; wb_sel_d = 0; write_d = 0; m_write_d = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (result !== 32'd0) $display("FAIL reset_result got=%h exp=0", result); else n_pass++;
    n_checks++; if (pc !== 16'd0) $display("FAIL reset_pc got=%h exp=0", pc); else n_pass++;
    n_checks++; if ({writeregsel, wb_sel, write, m_write} !== 8'd0)
      $display("FAIL reset_ctrl got=%b exp=0", {writeregsel, wb_sel, write, m_write}); else n_pass++;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
    rst_n = 1;
  endtask

  task automatic test_alu();
    @(posedge clk); #1;
    read1data = 5; read2data = 7; alu_op = 4'd0; write_d = 1; writeregsel_d = 5'd2; pc_d = 16'h0004;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL add_stall got=%b exp=0", stall); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (result !== 32'd12) $display("FAIL add_result got=%0d exp=12", result); else n_pass++;
    n_checks++; if (write !== 1'b1 || writeregsel !== 5'd2) $display("FAIL add_ctrl got=%b/%0d exp=1/2", write, writeregsel); else n_pass++;
    n_checks++; if (pc !== 16'h0005) $display("FAIL add_pc got=%h exp=0005", pc); else n_pass++;
    imm_sel = 1; imm = 100;
    @(posedge clk); #1;
    n_checks++; if (result !== 32'd105) $display("FAIL add_imm got=%0d exp=105", result); else n_pass++;
    imm_sel = 0; alu_op = 4'd1;
    @(posedge clk); #1;
    n_checks++; if (result !== 32'hFFFF_FFFE) $display("FAIL sub got=%h exp=fffffffe", result); else n_pass++;
    branch = 2'd3; imm = 32'h10;
    @(posedge clk); #1;
    n_checks++; if (pc !== 16'h0014) $display("FAIL jmp_pc got=%h exp=0014", pc); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
    logic [31:0] prev;
    int          stalls;
    bit          bubble_ok;
    @(posedge clk); #1;
    prev = result;
    md_en = 1; md_op = op; read1data = a; read2data = b; imm_sel = 0; branch = 2'd0;
    write_d = 1; m_write_d = 0; wb_sel_d = 1; writeregsel_d = 5'd9; pc_d = 16'h0040;
    stalls = 0; bubble_ok = 1;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (stall) stalls++;
      @(posedge clk); #1;
      if (i < 34 && (write !== 1'b0 || m_write !== 1'b0 || result !== prev)) bubble_ok = 0;
    end
    md_en = 0; write_d = 0; wb_sel_d = 0;
    n_checks++; if (stalls != 33) $display("FAIL %s_stall_cycles got=%0d exp=33", name, stalls); else n_pass++;
    n_checks++; if (!bubble_ok) $display("FAIL %s_bubble got=0 exp=1", name); else n_pass++;
    n_checks++; if (result !== exp) $display("FAIL %s_result got=%h exp=%h", name, result, exp); else n_pass++;
    n_checks++; if (write !== 1'b1 || m_write !== 1'b0 || wb_sel !== 1'b1 || writeregsel !== 5'd9)
      $display("FAIL %s_ctrl got=%b%b%b/%0d exp=101/9", name, write, m_write, wb_sel, writeregsel); else n_pass++;
    n_checks++; if (pc !== 16'h0041) $display("FAIL %s_pc got=%h exp=0041", name, pc); else n_pass++;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL %s_after_stall got=%b exp=0", name, stall); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    md_en = 1; md_op = 2'b10; read1data = 100; read2data = 7;
    write_d = 1; m_write_d = 1; pc_d = 16'h0050;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1; pc_d = 16'h0077;
    @(posedge clk); #1;
    flush = 0; md_en = 0;
    n_checks++; if (write !== 1'b0 || m_write !== 1'b0) $display("FAIL flush_we got=%b%b exp=00", write, m_write); else n_pass++;
    n_checks++; if (pc !== 16'h0077) $display("FAIL flush_pc got=%h exp=0077", pc); else n_pass++;
    read1data = 3; read2data = 4; alu_op = 4'd0; write_d = 1; m_write_d = 0; pc_d = 16'h0078;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (result !== 32'd7 || write !== 1'b1 || pc !== 16'h0079)
      $display("FAIL flush_next_add got=%0d/%b/%h exp=7/1/0079", result, write, pc); else n_pass++;
    md_en = 1; md_op = 2'b00; flush = 1; pc_d = 16'h0090; write_d = 1;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL idle_flush_stall got=%b exp=0", stall); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (write !== 1'b0 || pc !== 16'h0090) $display("FAIL idle_flush got=%b/%h exp=0/0090", write, pc); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    md_en = 1; md_op = 2'b00; read1data = 7; read2data = 6; write_d = 1; wb_sel_d = 1;
    writeregsel_d = 5'd4; pc_d = 16'h0060;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 0; md_en = 0;
    @(posedge clk); #1;
    rst_n = 1;
    n_checks++; if (result !== 32'd0 || pc !== 16'd0) $display("FAIL midrst_data got=%h/%h exp=0/0", result, pc); else n_pass++;
    n_checks++; if ({writeregsel, wb_sel, write, m_write} !== 8'd0)
      $display("FAIL midrst_ctrl got=%b exp=0", {writeregsel, wb_sel, write, m_write}); else n_pass++;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL midrst_stall got=%b exp=0", stall); else n_pass++;
    idle_inputs();
    test_md(2'b00, 32'd7, 32'd6, 32'd42, "mul_reissue");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_md(2'b00, 32'd7, 32'd6, 32'd42, "mul");
    test_md(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    test_md(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_max");
    test_md(2'b10, 32'd100, 32'd7, 32'd14, "divu");
    test_md(2'b11, 32'd100, 32'd7, 32'd2, "remu");
    test_md(2'b10, 32'd9, 32'd0, 32'hFFFF_FFFF, "divu_zero");
    test_md(2'b11, 32'd9, 32'd0, 32'd9, "remu_zero");
    test_flush();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
